// File: rtl/ketchup_core_feeder_if.sv
// Front-end word stream plus the keccak core feed/handshake signals, viewed from
// the feeder (slave) and from its environment (master).
interface ketchup_core_feeder_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic [1:0]  s_byte_num;

  logic [31:0] core_in;
  logic        core_in_ready;
  logic        core_is_last;
  logic [1:0]  core_byte_num;
  logic        core_reset;
  logic        core_buffer_full;
  logic        core_out_ready;

  modport master (
    output s_valid, s_data, s_last, s_byte_num,
    input  s_ready,
    input  core_in, core_in_ready, core_is_last, core_byte_num, core_reset,
    output core_buffer_full, core_out_ready
  );

  modport slave (
    input  s_valid, s_data, s_last, s_byte_num,
    output s_ready,
    output core_in, core_in_ready, core_is_last, core_byte_num, core_reset,
    input  core_buffer_full, core_out_ready
  );
endinterface

// File: rtl/ketchup_core_feeder.sv
// Queues front-end words and feeds them one per two cycles to the keccak core (registered strobe one cycle after pop),
// stalling on core_buffer_full and holding the next message until digest_ack; KETCHUP_FEEDER_STATS_EN builds word_count.
module ketchup_feeder_fifo #(
  parameter int DW = 35,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] pop_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full    = (level == DEPTH);
  assign empty   = (level == '0);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

module ketchup_core_feeder #(
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int C_DATA_WIDTH    = 32
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic                     flush,
  input  logic                     digest_ack,
  ketchup_core_feeder_if.slave     ifc,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level,
  output logic                     busy,
  output logic [15:0]              word_count
);
  typedef struct packed {
    logic [C_DATA_WIDTH-1:0] data;
    logic                    last;
    logic [1:0]              byte_num;
  } entry_t;

  typedef enum logic [1:0] {RESET_CORE, FEED, WAIT_DIGEST} state_t;

  state_t state;
  state_t next_state;

  entry_t push_ent;
  entry_t head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   push;
  logic   pop;

  logic                    issue_strobe;
  logic [C_DATA_WIDTH-1:0] issue_data;
  logic                    issue_last;
  logic [1:0]              issue_bytes;

  logic unused_core_out_ready;
  assign unused_core_out_ready = ifc.core_out_ready;

  assign ifc.s_ready = !fifo_full && !flush && (state != RESET_CORE);
  assign push        = ifc.s_valid && ifc.s_ready;

  // byte count only means something on the final word; keep it zero elsewhere
  assign push_ent.data     = ifc.s_data;
  assign push_ent.last     = ifc.s_last;
  assign push_ent.byte_num = ifc.s_last ? ifc.s_byte_num : 2'b00;

  ketchup_feeder_fifo #(
    .DW ($bits(entry_t)),
    .AW (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .clr      (flush),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state <= RESET_CORE;
    end else begin
      state <= next_state;
    end
  end

  // gating on issue_strobe spaces issues so the core's buffer_full has caught up
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    if (flush) begin
      next_state = RESET_CORE;
    end else begin
      case (state)
        RESET_CORE: next_state = FEED;
        FEED: begin
          if (!fifo_empty && !ifc.core_buffer_full && !issue_strobe) begin
            pop = 1'b1;
            if (head.last) next_state = WAIT_DIGEST;
          end
        end
        WAIT_DIGEST: begin
          if (digest_ack) next_state = RESET_CORE;
        end
        default: next_state = RESET_CORE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      issue_strobe <= 1'b0;
      issue_data   <= '0;
      issue_last   <= 1'b0;
      issue_bytes  <= 2'b00;
    end else begin
      issue_strobe <= pop;
      if (pop) begin
        issue_data  <= head.data;
        issue_last  <= head.last;
        issue_bytes <= head.byte_num;
      end
    end
  end

  assign ifc.core_in       = issue_data;
  assign ifc.core_in_ready = issue_strobe;
  assign ifc.core_is_last  = issue_last;
  assign ifc.core_byte_num = issue_bytes;
  assign ifc.core_reset    = (state == RESET_CORE);

  assign busy = (state != FEED) || !fifo_empty;

`ifdef KETCHUP_FEEDER_STATS_EN
  logic [15:0] count;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      count <= 16'h0000;
    end else if (next_state == RESET_CORE) begin
      count <= 16'h0000;
    end else if (pop && (count != 16'hFFFF)) begin
      count <= count + 16'h0001;
    end
  end

  assign word_count = count;
`else
  assign word_count = 16'h0000;
`endif
endmodule

// File: tb/tb_ketchup_core_feeder.sv
// Directed bench for ketchup_core_feeder: queue-based reference model checked every cycle plus literal expectations.
module tb_ketchup_core_feeder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        digest_ack = 1'b0;
  logic [3:0]  fifo_level;
  logic        busy;
  logic [15:0] word_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  ketchup_core_feeder_if ifc ();

  ketchup_core_feeder #(.FIFO_DEPTH_LOG2(3), .C_DATA_WIDTH(32)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .flush         (flush),
    .digest_ack    (digest_ack),
    .ifc           (ifc),
    .fifo_level    (fifo_level),
    .busy          (busy),
    .word_count    (word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: phase 0 = core being reset, 1 = feeding, 2 = waiting for digest ack
  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [1:0]  b;
  } ent_t;

  ent_t mq[$];
  int   m_phase;
  logic m_strobe;
  ent_t m_out;
  int   m_wc;
  bit   m_can_push;
  bit   m_issue;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_phase  = 0;
      m_strobe = 1'b0;
      m_out    = '{32'h0, 1'b0, 2'd0};
      m_wc     = 0;
    end else begin
      m_can_push = (mq.size() < 8) && !flush && (m_phase != 0);
      m_issue    = (m_phase == 1) && (mq.size() != 0) && !ifc.core_buffer_full && !m_strobe;
      if (flush) begin
        mq.delete();
        m_strobe = 1'b0;
        m_phase  = 0;
        m_wc     = 0;
      end else begin
        m_strobe = m_issue;
        if (m_issue) begin
          m_out = mq.pop_front();
          if (m_wc < 65535) m_wc++;
          if (m_out.l) m_phase = 2;
        end else if (m_phase == 0) begin
          m_phase = 1;
        end else if (m_phase == 2 && digest_ack) begin
          m_phase = 0;
          m_wc    = 0;
        end
        if (ifc.s_valid && m_can_push)
          mq.push_back('{ifc.s_data, ifc.s_last, ifc.s_last ? ifc.s_byte_num : 2'd0});
      end
    end
  end

  logic [31:0] log_d[$];
  logic        log_l[$];
  logic [1:0]  log_b[$];
  int          log_c[$];
  int          rst_hi = 0;

  always @(negedge clk) begin
    check("core_reset", ifc.core_reset, m_phase == 0);
    check("core_in_ready", ifc.core_in_ready, m_strobe);
    check("core_in", ifc.core_in, m_out.d);
    check("core_is_last", ifc.core_is_last, m_out.l);
    check("core_byte_num", ifc.core_byte_num, m_out.b);
    check("fifo_level", fifo_level, mq.size());
    check("s_ready", ifc.s_ready, (mq.size() < 8) && !flush && (m_phase != 0));
    check("busy", busy, (m_phase != 1) || (mq.size() != 0));
`ifdef KETCHUP_FEEDER_STATS_EN
    check("word_count", word_count, m_wc);
`else
    check("word_count", word_count, 0);
`endif
    if (rst_n && ifc.core_in_ready) begin
      log_d.push_back(ifc.core_in);
      log_l.push_back(ifc.core_is_last);
      log_b.push_back(ifc.core_byte_num);
      log_c.push_back(cyc);
    end
    if (rst_n && ifc.core_reset) rst_hi++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic l, input logic [1:0] b);
    bit done = 0;
    ifc.s_valid = 1'b1;
    ifc.s_data = d;
    ifc.s_last = l;
    ifc.s_byte_num = b;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (ifc.s_ready) done = 1;
      @(posedge clk);
      #1;
    end
    ifc.s_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: word 0x%0h never accepted, expected acceptance within 100 cycles", d);
    end
  endtask

  task automatic pulse_ack();
    digest_ack = 1'b1;
    tick(1);
    digest_ack = 1'b0;
  endtask

  task automatic clear_log();
    log_d.delete();
    log_l.delete();
    log_b.delete();
    log_c.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.s_valid = 1'b0;
    ifc.s_data = 32'h0;
    ifc.s_last = 1'b0;
    ifc.s_byte_num = 2'd0;
    ifc.core_buffer_full = 1'b0;
    ifc.core_out_ready = 1'b0;

    tick(2);
    check("rst_core_reset", ifc.core_reset, 1);
    check("rst_core_in_ready", ifc.core_in_ready, 0);
    check("rst_core_in", ifc.core_in, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_word_count", word_count, 0);
    check("rst_s_ready", ifc.s_ready, 0);
    rst_n = 1'b1;

    // message of three words; non-last byte_num must be masked to 0
    push(32'h11111111, 1'b0, 2'd3);
    push(32'h22222222, 1'b0, 2'd0);
    push(32'h33333333, 1'b1, 2'd2);
    tick(10);
    check("t1_count", log_d.size(), 3);
    if (log_d.size() == 3) begin
      check("t1_w0", log_d[0], 32'h11111111);
      check("t1_w1", log_d[1], 32'h22222222);
      check("t1_w2", log_d[2], 32'h33333333);
      check("t1_last0", log_l[0], 0);
      check("t1_last2", log_l[2], 1);
      check("t1_bn0", log_b[0], 0);
      check("t1_bn2", log_b[2], 2);
      check("t1_gap01", (log_c[1] - log_c[0]) >= 2, 1);
      check("t1_gap12", (log_c[2] - log_c[1]) >= 2, 1);
    end
    check("t1_reset_cycles", rst_hi, 1);
    check("t1_busy_wait", busy, 1);
`ifdef KETCHUP_FEEDER_STATS_EN
    check("t1_word_count", word_count, 3);
`endif

    // fill FIFO while core is full
    clear_log();
    ifc.core_buffer_full = 1'b1;
    pulse_ack();
    for (int i = 0; i < 8; i++) push(32'hA0000000 + i, 1'b0, 2'd1);
    ifc.s_valid = 1'b1;
    ifc.s_data = 32'hA0000008;
    ifc.s_last = 1'b1;
    ifc.s_byte_num = 2'd0;
    tick(3);
    check("t2_level_full", fifo_level, 8);
    check("t2_s_ready_full", ifc.s_ready, 0);
    check("t2_no_issue", log_d.size(), 0);
    ifc.core_buffer_full = 1'b0;
    push(32'hA0000008, 1'b1, 2'd0);
    tick(30);
    check("t2_count", log_d.size(), 9);
    if (log_d.size() == 9) begin
      for (int i = 0; i < 9; i++) check("t2_order", log_d[i], 32'hA0000000 + i);
      check("t2_last8", log_l[8], 1);
      check("t2_bn3", log_b[3], 0);
    end
    check("t2_level_empty", fifo_level, 0);
    check("t2_reset_cycles", rst_hi, 2);

    // next message queued during WAIT_DIGEST
    clear_log();
    ifc.core_out_ready = 1'b1;
    push(32'hB1B1B1B1, 1'b0, 2'd0);
    push(32'hB2B2B2B2, 1'b1, 2'd1);
    tick(8);
    check("t3_held", log_d.size(), 0);
    check("t3_level", fifo_level, 2);
    check("t3_no_reset", rst_hi, 2);
    ifc.core_out_ready = 1'b0;
    pulse_ack();
    tick(10);
    check("t3_count", log_d.size(), 2);
    if (log_d.size() == 2) begin
      check("t3_w0", log_d[0], 32'hB1B1B1B1);
      check("t3_w1", log_d[1], 32'hB2B2B2B2);
      check("t3_bn1", log_b[1], 1);
    end
    check("t3_reset_cycles", rst_hi, 3);

    // digest_ack while feeding is ignored
    pulse_ack();
    tick(2);
    clear_log();
    ifc.core_buffer_full = 1'b1;
    push(32'hC0000001, 1'b0, 2'd0);
    push(32'hC0000002, 1'b0, 2'd0);
    push(32'hC0000003, 1'b1, 2'd0);
    ifc.core_buffer_full = 1'b0;
    pulse_ack();
    tick(12);
    check("t4_count", log_d.size(), 3);
    if (log_d.size() == 3) begin
      check("t4_w0", log_d[0], 32'hC0000001);
      check("t4_w2", log_d[2], 32'hC0000003);
      check("t4_gap", log_c[1] - log_c[0], 2);
    end
    check("t4_no_reset", rst_hi, 4);

    // flush with five queued words and a word offered in the same cycle
    pulse_ack();
    tick(2);
    clear_log();
    ifc.core_buffer_full = 1'b1;
    for (int i = 0; i < 5; i++) push(32'hD0000000 + i, 1'b0, 2'd0);
    check("t5_level5", fifo_level, 5);
    flush = 1'b1;
    ifc.s_valid = 1'b1;
    ifc.s_data = 32'hDEADBEEF;
    ifc.s_last = 1'b0;
    @(negedge clk);
    check("t5_s_ready_flush", ifc.s_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    ifc.s_valid = 1'b0;
    @(negedge clk);
    check("t5_level0", fifo_level, 0);
    check("t5_core_reset", ifc.core_reset, 1);
    @(posedge clk);
    #1;
    ifc.core_buffer_full = 1'b0;
    tick(10);
    check("t5_no_issue", log_d.size(), 0);
    check("t5_reset_once", rst_hi, 6);

    // asynchronous reset mid-message
    ifc.core_buffer_full = 1'b1;
    push(32'hE0000000, 1'b0, 2'd0);
    push(32'hE0000001, 1'b0, 2'd0);
    push(32'hE0000002, 1'b0, 2'd0);
    check("t6_level3", fifo_level, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_core_reset", ifc.core_reset, 1);
    check("t6_async_level", fifo_level, 0);
    check("t6_async_strobe", ifc.core_in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ifc.core_buffer_full = 1'b0;
    clear_log();
    push(32'hF0F0F0F0, 1'b1, 2'd3);
    tick(6);
    check("t6_count", log_d.size(), 1);
    if (log_d.size() == 1) begin
      check("t6_w0", log_d[0], 32'hF0F0F0F0);
      check("t6_bn", log_b[0], 3);
    end
`ifdef KETCHUP_FEEDER_STATS_EN
    check("t6_word_count", word_count, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ketchup_core_feeder.md
Name: ketchup_core_feeder

Overview:
- Sits between the AXI-Lite register front end and the keccak core.
- Buffers message words from the front end in a small FIFO and issues them to the core one at a time, honouring the core's buffer_full backpressure.
- Sequences the per-message core lifecycle: feed words, then wait for the digest to be acknowledged, then reset the core.
- Decouples software write rate from core absorption rate.

Parameters:
FIFO_DEPTH_LOG2, 3, log2 of FIFO entries (8 entries by default); each entry holds data[31:0], last, byte_num[1:0].
C_DATA_WIDTH, 32, word width; only 32 is supported.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset, asynchronous, active-low
flush  in  1  sync pulse: discard all queued words and restart the core
digest_ack  in  1  sync pulse: software has read the digest
s_valid  in  1  word offered by the front end
s_ready  out  1  feeder accepts the word this cycle
s_data  in  32  message word
s_last  in  1  final word of the message
s_byte_num  in  2  valid bytes in the final word (0 = full word per core convention)
core_in  out  32  word to the core
core_in_ready  out  1  one-cycle strobe: core_in is valid
core_is_last  out  1  qualifies core_in_ready
core_byte_num  out  2  qualifies core_in_ready
core_reset  out  1  active-high core reset
core_buffer_full  in  1  core cannot absorb a word
core_out_ready  in  1  core digest valid (level)
fifo_level  out  FIFO_DEPTH_LOG2+1  current occupancy
busy  out  1  state != FEED or FIFO not empty
word_count  out  16  see Optional Feature

Behaviour:
- Reset values:
  - core_reset=1; state=RESET_CORE.
  - core_in=0, core_in_ready=0, core_is_last=0, core_byte_num=0.
  - FIFO empty; fifo_level=0; word_count=0.
- States:
  - RESET_CORE: core_reset=1 for exactly one cycle, then FEED.
  - FEED: pops and issues words.
  - WAIT_DIGEST: no pops. On digest_ack, go to RESET_CORE. digest_ack is ignored in the other states.
- Push:
  - s_ready = !fifo_full && !flush && state != RESET_CORE, combinational.
  - Push occurs when s_valid && s_ready.
  - The FIFO stores s_last, and stores s_byte_num only when s_last=1; otherwise it stores 0.
- Pop/issue:
  - Pop occurs in FEED when FIFO not empty && !core_buffer_full && !core_in_ready.
  - Issue is never back-to-back: the core updates buffer_full one cycle after an accepted word.
  - Outputs are registered, so core_in_ready goes high the cycle after the pop decision.
  - core_in, core_is_last and core_byte_num hold their values until the next issue.
  - core_is_last=0 and core_byte_num=0 on non-last words.
- Issuing a last word moves the state to WAIT_DIGEST in the same edge.
  - Words for the next message may keep queuing, up to full.
  - They are issued only after RESET_CORE.
- Simultaneous push and pop: occupancy unchanged. Pointers wrap modulo 2^FIFO_DEPTH_LOG2; fifo_level counts 0..depth.
- flush has highest priority, from any state:
  - FIFO cleared.
  - Any push in that cycle is dropped.
  - core_in_ready forced 0 next cycle.
  - State goes to RESET_CORE.
- core_out_ready is informational only; it never alters state. The digest stays valid until digest_ack, because only the RESET_CORE state clears the core.
- Asynchronous reset mid-message: all state is lost; core_reset asserts immediately.

Optional Feature:
KETCHUP_FEEDER_STATS_EN
- Defined:
  - word_count increments on every issued word and saturates at 16'hFFFF.
  - It clears on entry to RESET_CORE, so it reads the word total of the current or last message until its digest is acknowledged.
- Undefined: word_count is tied to 0; no counter logic is built. The port stays present so the front-end interface is unchanged.

Test Plan:
- Reset release then 3 words 0x11111111, 0x22222222, 0x33333333 (last, byte_num=2), core_buffer_full=0:
  - core_reset high exactly one cycle after reset release.
  - Three core_in_ready strobes at least 2 cycles apart, only the third with core_is_last=1, core_byte_num=2.
  - State ends in WAIT_DIGEST; word_count=3 with STATS_EN.
- Push 8 words with core_buffer_full=1:
  - s_ready=0 once fifo_level=8, ninth word stalls, core_in_ready never asserts.
  - After buffer_full drops, all 8 words are issued in order and fifo_level returns to 0.
- In WAIT_DIGEST, push 2 words of the next message:
  - No issue occurs until digest_ack.
  - Then core_reset pulses one cycle and both words issue in order.
- flush asserted while fifo_level=5 together with s_valid=1:
  - fifo_level=0 next cycle; the word offered in the flush cycle is dropped.
  - core_reset pulses once; no further core_in_ready.
- digest_ack pulsed in FEED: ignored; no core_reset; issuing continues uninterrupted.
- S_AXI_ARESETN asserted mid-message with fifo_level=3: core_reset=1 and fifo_level=0 asynchronously, before the next clock edge.
